// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider, responder side of the
// EX-stage start/ready divide handshake.
//
// EX raises start_i with the operands and holds it while ready_o is low.
// When ready_o rises, EX takes result_o into HI/LO and drops start_i, which
// returns the divider to IDLE. Signed (DIV) and unsigned (DIVU) are both
// supported. A non-zero divide always takes exactly WIDTH steps. A
// divide-by-zero finishes two edges after acceptance with a zero result.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous reset, active-high, beats everything
//   signed_div_i  1 = signed divide, sampled only on acceptance
//   opdata1_i     dividend, sampled only on acceptance
//   opdata2_i     divisor, sampled only on acceptance
//   start_i       level request, held by EX until ready_o is seen
//   annul_i       abort the current operation (beats start_i)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ZERO = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  // dvd starts as |dividend| and fills up with quotient bits from the LSB
  // as the dividend bits shift out of the MSB into the partial remainder.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;

  // Operand magnitudes at acceptance. Negating 0x80000000 gives
  // 0x80000000 again, which is the correct unsigned magnitude.
  logic             sign1, sign2;
  logic [WIDTH-1:0] abs1, abs2;

  always_comb begin
    sign1 = signed_div_i & opdata1_i[WIDTH-1];
    sign2 = signed_div_i & opdata2_i[WIDTH-1];
    abs1  = sign1 ? -opdata1_i : opdata1_i;
    abs2  = sign2 ? -opdata2_i : opdata2_i;
  end

  // One restoring step. The shifted remainder needs WIDTH+1 bits because
  // rem < dsr <= 2^WIDTH-1, so 2*rem+1 can exceed WIDTH bits.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  always_comb begin
    rem_sh  = {rem, dvd[WIDTH-1]};
    diff    = rem_sh - {1'b0, dsr};
    qbit    = ~diff[WIDTH];
    rem_nxt = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_nxt = {dvd[WIDTH-2:0], qbit};
    // Sign correction on the final step; the quotient wraps modulo 2^WIDTH
    // and the remainder follows the sign of the dividend.
    q_fin   = neg_q ? -dvd_nxt : dvd_nxt;
    r_fin   = neg_r ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            cnt <= '0;
            rem <= '0;
            if (opdata2_i == '0) begin
              state <= S_ZERO;
            end else begin
              state <= S_BUSY;
              dvd   <= abs1;
              dsr   <= abs2;
              neg_q <= sign1 ^ sign2;
              neg_r <= sign1;
            end
          end
        end

        // Divide-by-zero spends two edges here so ready_o appears two
        // edges after acceptance; cnt marks the first of them.
        S_ZERO: begin
          if (annul_i) begin
            state    <= S_IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (cnt != '0) begin
            state    <= S_DONE;
            ready_o  <= 1'b1;
            result_o <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_BUSY: begin
          if (annul_i) begin
            state    <= S_IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            dvd <= dvd_nxt;
            rem <= rem_nxt;
            cnt <= cnt + CW'(1);
            if (cnt == LAST_STEP) begin
              state    <= S_DONE;
              ready_o  <= 1'b1;
              result_o <= {r_fin, q_fin};
            end
          end
        end

        // Hold the result until EX drops start_i; a restart must go
        // through IDLE first.
        S_DONE: begin
          if (annul_i || !start_i) begin
            state    <= S_IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end

        default: begin
          state    <= S_IDLE;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start an op at edge N, confirm ready_o stays low until edge N+lat and
  // then carries exp. Operands are scrambled right after acceptance to show
  // they are latched. Unless hold is set, start is dropped and the return
  // to IDLE is checked.
  task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [63:0] exp,
                        input bit hold);
    int early = 0;
    @(negedge clk);
    signed_div = sg; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk);               // edge N
    #1;
    op1 = ~a; op2 = 32'h3; signed_div = ~sg;
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
      if (ready) early++;
    end
    check({tag, "_early"}, 64'(early), 64'd0);
    @(posedge clk); #1;           // edge N+lat
    check({tag, "_ready"}, {63'd0, ready}, 64'd1);
    check({tag, "_result"}, result, exp);
    if (!hold) begin
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      check({tag, "_idle_rdy"}, {63'd0, ready}, 64'd0);
      check({tag, "_idle_res"}, result, 64'd0);
    end
  endtask

  initial begin
    logic [63:0] held;
    int seen;
    rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op("u100_7",   1'b0, 32'd100,       32'd7,         32, 64'h00000002_0000000E, 1'b0);
    run_op("s-7_2",    1'b1, 32'hFFFFFFF9,  32'h00000002,  32, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_op("s7_-2",    1'b1, 32'h00000007,  32'hFFFFFFFE,  32, 64'h00000001_FFFFFFFD, 1'b0);
    run_op("s_min_m1", 1'b1, 32'h80000000,  32'hFFFFFFFF,  32, 64'h00000000_80000000, 1'b0);
    run_op("u_max_1",  1'b0, 32'hFFFFFFFF,  32'h00000001,  32, 64'h00000000_FFFFFFFF, 1'b0);
    run_op("u_min_max",1'b0, 32'h80000000,  32'hFFFFFFFF,  32, 64'h80000000_00000000, 1'b0);
    run_op("u_div0",   1'b0, 32'd1234,      32'd0,          2, 64'd0,                 1'b0);
    run_op("s_div0",   1'b1, 32'hFFFFFF00,  32'd0,          2, 64'd0,                 1'b0);

    // Annul at edge N+10: back to IDLE, no ready afterwards.
    @(negedge clk); signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(posedge clk);               // edge N
    repeat (9) @(posedge clk);    // edge N+9
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1;           // edge N+10
    check("annul_ready", {63'd0, ready}, 64'd0);
    check("annul_result", result, 64'd0);
    @(negedge clk); annul = 1'b0; start = 1'b0;
    seen = 0;
    repeat (35) begin @(posedge clk); #1; if (ready) seen++; end
    check("annul_no_ready", 64'(seen), 64'd0);
    run_op("post_annul", 1'b0, 32'd1000, 32'd3, 32, 64'h00000001_0000014D, 1'b0);

    // start held high in DONE for 5 cycles: result stable, ready stays 1.
    run_op("hold", 1'b1, 32'hFFFFFF9C, 32'd7, 32, 64'hFFFFFFFE_FFFFFFF2, 1'b1);
    held = result;
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (!ready || result !== held) seen++; end
    check("hold_stable", 64'(seen), 64'd0);
    check("hold_result", result, 64'hFFFFFFFE_FFFFFFF2);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("hold_release_rdy", {63'd0, ready}, 64'd0);
    check("hold_release_res", result, 64'd0);

    // Reset at edge N+15 mid-operation.
    @(negedge clk); signed_div = 1'b0; op1 = 32'd50; op2 = 32'd6; start = 1'b1;
    @(posedge clk);               // edge N
    repeat (14) @(posedge clk);   // edge N+14
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;           // edge N+15
    check("midrst_ready", {63'd0, ready}, 64'd0);
    check("midrst_result", result, 64'd0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    run_op("post_rst", 1'b0, 32'd50, 32'd6, 32, 64'h00000002_00000008, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
